// File: rtl/axi_pkg.sv
// Shared AXI3 codes, slave FSM encoding and latched-request layout.
package axi_pkg;
    localparam int ID_W_DEF = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    // WRAP is deliberately handled as INCR; only FIXED holds the address.
    function automatic logic [31:0] next_addr(input req_t r);
        return (r.burst == BURST_FIXED) ? r.addr : r.addr + (32'd1 << r.size);
    endfunction
endpackage

// File: rtl/sram_1rw_be.sv
// DEPTH x 32 storage: byte-enable synchronous write, combinational read.
module sram_1rw_be #(
    parameter int  DEPTH  = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave over a word SRAM; one transaction in flight, all outputs registered.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [3:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    input  logic [1:0]      arlock,
    input  logic [3:0]      arcache,
    input  logic [2:0]      arprot,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [3:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [1:0]      awlock,
    input  logic [3:0]      awcache,
    input  logic [2:0]      awprot,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);
    localparam int ADDR_W = $clog2(DEPTH);

    state_t          state, state_n;
    req_t            req, req_n;
    logic [3:0]      cnt, cnt_n;
    logic            err, err_n;
    logic            arready_n, awready_n, wready_n, rvalid_n, rlast_n, bvalid_n;
    logic [ID_W-1:0] rid_n, bid_n;
    logic [31:0]     rdata_n;
    logic [1:0]      rresp_n, bresp_n;
    logic [31:0]     req_adv, mem_rdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic            mem_we;

    logic unused_sig;
    assign unused_sig = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot};

    assign req_adv = next_addr(req);

    sram_1rw_be #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .be    (wstrb),
        .waddr (req.addr[ADDR_W+1:2]),
        .wdata (wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_n   = state;
        req_n     = req;
        cnt_n     = cnt;
        err_n     = err;
        arready_n = arready;
        awready_n = awready;
        wready_n  = wready;
        rvalid_n  = rvalid;
        rlast_n   = rlast;
        rdata_n   = rdata;
        rresp_n   = rresp;
        rid_n     = rid;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        bid_n     = bid;
        mem_we    = 1'b0;
        mem_raddr = req_adv[ADDR_W+1:2];
        case (state)
            IDLE: begin
                // Readies are granted from last cycle's valids, so a coincident AW always wins.
                awready_n = awvalid;
                arready_n = arvalid && !awvalid;
                mem_raddr = araddr[ADDR_W+1:2];
                if (awvalid && awready) begin
                    state_n   = WR;
                    awready_n = 1'b0;
                    arready_n = 1'b0;
                    wready_n  = 1'b1;
                    req_n     = '{addr: awaddr, len: awlen, size: awsize, burst: awburst};
                    bid_n     = awid;
                    cnt_n     = 4'd0;
                    err_n     = 1'b0;
                end else if (arvalid && arready) begin
                    state_n   = RD;
                    awready_n = 1'b0;
                    arready_n = 1'b0;
                    req_n     = '{addr: araddr, len: arlen, size: arsize, burst: arburst};
                    rid_n     = arid;
                    cnt_n     = 4'd0;
                    rvalid_n  = 1'b1;
                    rlast_n   = (arlen == 4'd0);
                    rdata_n   = mem_rdata;
                    rresp_n   = RESP_OKAY;
                end
            end
            RD: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        state_n  = IDLE;
                        rvalid_n = 1'b0;
                        rlast_n  = 1'b0;
                    end else begin
                        req_n.addr = req_adv;
                        rdata_n    = mem_rdata;
                        cnt_n      = cnt + 4'd1;
                        rlast_n    = (cnt + 4'd1 == req.len);
                    end
                end
            end
            WR: begin
                if (wvalid && wready) begin
                    mem_we = 1'b1;
                    // Burst length comes from the latched len; wlast only feeds the error flag.
                    if (cnt == req.len) begin
                        state_n  = WRESP;
                        wready_n = 1'b0;
                        bvalid_n = 1'b1;
                        bresp_n  = (err || !wlast) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        if (wlast) err_n = 1'b1;
                        req_n.addr = req_adv;
                        cnt_n      = cnt + 4'd1;
                    end
                end
            end
            WRESP: begin
                if (bvalid && bready) begin
                    state_n  = IDLE;
                    bvalid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            rid     <= '0;
            bvalid  <= 1'b0;
            bresp   <= '0;
            bid     <= '0;
        end else begin
            state   <= state_n;
            req     <= req_n;
            cnt     <= cnt_n;
            err     <= err_n;
            arready <= arready_n;
            awready <= awready_n;
            wready  <= wready_n;
            rvalid  <= rvalid_n;
            rlast   <= rlast_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
            rid     <= rid_n;
            bvalid  <= bvalid_n;
            bresp   <= bresp_n;
            bid     <= bid_n;
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a read-beat scoreboard and a reference memory.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int LIM = 50;

    logic        clk, rst;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [31:0] model [4096];
    int          n_chk = 0;
    int          n_fail = 0;

    axi_sram_slave #(.DEPTH(4096), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] size,
                                        input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    task automatic aw_hs(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        int k = 0;
        awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        while (!awready && k < LIM) begin @(negedge clk); k++; end
        chk("aw_timeout", 32'(k < LIM), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] a0, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                           input int err_beat, output logic err);
        logic [31:0] a = a0;
        logic [31:0] d;
        int k;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            d = base + 32'(i);
            wdata = d; wstrb = strb; wvalid = 1'b1;
            wlast = (err_beat < 0) ? (i == int'(len)) : (i == err_beat);
            if (wlast != (i == int'(len))) err = 1'b1;
            k = 0;
            while (!wready && k < LIM) begin @(negedge clk); k++; end
            chk("w_timeout", 32'(k < LIM), 32'd1);
            for (int b = 0; b < 4; b++) if (strb[b]) model[a[13:2]][8*b +: 8] = d[8*b +: 8];
            a = adv(a, size, burst);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_resp(input logic [1:0] exp_resp, input logic [3:0] exp_id);
        int k = 0;
        bready = 1'b1;
        while (!bvalid && k < LIM) begin @(negedge clk); k++; end
        chk("b_timeout", 32'(k < LIM), 32'd1);
        chk("bresp", 32'(bresp), 32'(exp_resp));
        chk("bid", 32'(bid), 32'(exp_id));
        @(negedge clk);
        bready = 1'b0;
        chk("b_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic ar_hs(input logic [31:0] a0, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        logic [31:0] a = a0;
        int k = 0;
        araddr = a0; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        while (!arready && k < LIM) begin @(negedge clk); k++; end
        chk("ar_timeout", 32'(k < LIM), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            sb.push_back('{data: model[a[13:2]], last: (i == int'(len)), id: id});
            a = adv(a, size, burst);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic r_beats(input logic [3:0] pat, input int stop_after);
        int          got = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] sd = '0;
        logic        sl = 1'b0;
        rd_exp_t     e;
        while (sb.size() > 0 && cyc < 200 && (stop_after == 0 || got < stop_after)) begin
            chk("r_valid", 32'(rvalid), 32'd1);
            if (stalled) begin
                chk("r_hold_data", rdata, sd);
                chk("r_hold_last", 32'(rlast), 32'(sl));
            end
            rready = pat[2'(cyc)];
            if (rvalid && rready) begin
                e = sb.pop_front();
                chk("r_data", rdata, e.data);
                chk("r_last", 32'(rlast), 32'(e.last));
                chk("r_id", 32'(rid), 32'(e.id));
                chk("r_resp", 32'(rresp), 32'(RESP_OKAY));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = rvalid; sd = rdata; sl = rlast;
            end
            cyc++;
            @(negedge clk);
        end
        rready = 1'b0;
        chk("r_timeout", 32'(cyc < 200), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [31:0] base,
                            input logic [3:0] strb, input int err_beat);
        logic e;
        aw_hs(a, len, size, burst, id);
        w_beats(a, len, size, burst, base, strb, err_beat, e);
        b_resp(e ? RESP_SLVERR : RESP_OKAY, id);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [3:0] pat);
        ar_hs(a, len, size, burst, id);
        r_beats(pat, 0);
        chk("r_end", 32'(rvalid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        {arid, araddr, arlen, arsize, arburst, arvalid, arlock, arcache, arprot} = '0;
        {awid, awaddr, awlen, awsize, awburst, awvalid, awlock, awcache, awprot} = '0;
        {wid, wdata, wstrb, wlast, wvalid, rready, bready} = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'({arready, awready, wready}), 32'd0);
        chk("rst_valid", 32'({rvalid, bvalid, rlast}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", 32'({rresp, bresp, rid, bid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single write then read
        do_write(32'h100, 4'd0, 3'd2, BURST_INCR, 4'd3, 32'hDEADBEEF, 4'hF, -1);
        do_read(32'h100, 4'd0, 3'd2, BURST_INCR, 4'd5, 4'hF);

        // cacheline burst
        do_write(32'h1FE0, 4'd7, 3'd2, BURST_INCR, 4'd2, 32'd0, 4'hF, -1);
        do_read(32'h1FE0, 4'd7, 3'd2, BURST_INCR, 4'd1, 4'hF);

        // byte strobes, narrow write
        do_write(32'h200, 4'd0, 3'd2, BURST_INCR, 4'd4, 32'h11223344, 4'hF, -1);
        do_write(32'h202, 4'd0, 3'd0, BURST_INCR, 4'd4, 32'h00AA0000, 4'b0100, -1);
        ar_hs(32'h200, 4'd0, 3'd2, BURST_INCR, 4'd0);
        chk("strb_word", sb[0].data, 32'h11AA3344);
        r_beats(4'hF, 0);

        // read backpressure
        do_read(32'h1FE0, 4'd7, 3'd2, BURST_INCR, 4'd9, 4'b1001);

        // simultaneous AW/AR
        araddr = 32'h300; arlen = 4'd0; arsize = 3'd2; arburst = BURST_INCR; arid = 4'd6; arvalid = 1'b1;
        awaddr = 32'h300; awlen = 4'd0; awsize = 3'd2; awburst = BURST_INCR; awid = 4'd7; awvalid = 1'b1;
        @(negedge clk);
        chk("sim_awready", 32'(awready), 32'd1);
        chk("sim_arready", 32'(arready), 32'd0);
        begin
            logic e;
            aw_hs(32'h300, 4'd0, 3'd2, BURST_INCR, 4'd7);
            chk("sim_ar_blocked", 32'(arready), 32'd0);
            w_beats(32'h300, 4'd0, 3'd2, BURST_INCR, 32'hCAFEF00D, 4'hF, -1, e);
            b_resp(RESP_OKAY, 4'd7);
        end
        do_read(32'h300, 4'd0, 3'd2, BURST_INCR, 4'd6, 4'hF);

        // wlast errors: early on beat 2, and missing on the final beat
        do_write(32'h400, 4'd3, 3'd2, BURST_INCR, 4'd8, 32'h40, 4'hF, 1);
        do_write(32'h440, 4'd3, 3'd2, BURST_INCR, 4'd8, 32'h80, 4'hF, 99);
        do_read(32'h400, 4'd3, 3'd2, BURST_INCR, 4'd2, 4'hF);

        // reset during beat 3 of an 8-beat read
        ar_hs(32'h1FE0, 4'd7, 3'd2, BURST_INCR, 4'd3);
        r_beats(4'hF, 2);
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(32'h100, 4'd0, 3'd2, BURST_INCR, 4'd5, 4'hF);

        // FIXED burst keeps hitting one word
        do_write(32'h500, 4'd1, 3'd2, BURST_FIXED, 4'd1, 32'h55, 4'hF, -1);
        do_read(32'h500, 4'd1, 3'd2, BURST_FIXED, 4'd1, 4'hF);

        // 16-beat burst wrapping past the top of the array
        do_write(32'h3FF8, 4'd15, 3'd2, BURST_INCR, 4'd15, 32'hA000, 4'hF, -1);
        do_read(32'h3FF8, 4'd15, 3'd2, BURST_INCR, 4'd15, 4'b1011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder backed by an internal word-wide SRAM array.
- It is the target end of the AXI master interface used by our cache/uncache bus controller.
- It serves 8-beat cacheline bursts and single narrow uncached accesses, one transaction at a time.
- It is used as the memory model in CPU-level simulation and as on-chip scratch RAM.

Parameters:
- DEPTH, 4096, number of 32-bit words; the index is addr[ADDR_W+1:2] with ADDR_W = clog2(DEPTH), and the address wraps modulo DEPTH.
- ID_W, 4, width of the AXI ID fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- arid  in  ID_W  read ID
- araddr  in  32  read start address
- arlen  in  4  beats-1
- arsize  in  3  bytes per beat is 2^arsize (maximum 2)
- arburst  in  2  burst type
- arvalid  in  1  read address valid
- arready  out  1  read address accepted
- rid  out  ID_W  equals latched arid
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  read data valid
- rready  in  1  master accepts read data
- awid  in  ID_W  write ID
- awaddr  in  32  write start address
- awlen  in  4  beats-1
- awsize  in  3  bytes per beat is 2^awsize
- awburst  in  2  burst type
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wid  in  ID_W  ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  master's last-beat flag
- wvalid  in  1  write data valid
- wready  out  1  slave accepts write data
- bid  out  ID_W  equals latched awid
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  master accepts response
- arlock, arcache, arprot, awlock, awcache, awprot  in  (2, 4, 3 each)  ignored

Behaviour:
- All outputs are registered.
- On rst, asynchronously, every output goes to 0 and the FSM goes to IDLE. SRAM contents are not reset.
- Reset mid-burst abandons the transaction; no response is ever issued for it.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE:
  - awready=1 while arready=0 whenever awvalid=1.
  - Otherwise arready=1.
  - Write has priority when awvalid and arvalid are both high in the same cycle; the AR is taken after the write completes.
- AR handshake:
  - Latch id, address, len, size and burst; beat counter=0.
  - Next cycle: RD, rvalid=1, rdata=mem[addr], rlast=(len==0), rresp=00.
- RD:
  - rvalid, rdata and rlast are held stable while rready=0.
  - On rvalid&&rready with !rlast: advance the address, and next cycle present the next beat. Throughput is 1 beat/cycle, with no rvalid bubble.
  - On the last handshake: rvalid=0 and return to IDLE next cycle.
- Address advance:
  - INCR (01), and WRAP (10/11) treated as INCR: addr += 1<<size.
  - FIXED (00): addr unchanged.
  - Sizes narrower than a word return the full word containing addr; byte lanes are not rotated.
- AW handshake:
  - Latch fields.
  - Next cycle: WR, wready=1.
- WR:
  - On each wvalid&&wready, write bytes i where wstrb[i]=1 into mem[index]; wstrb=0000 writes nothing. Then advance the address.
  - The burst ends on the beat where the counter equals the latched len, not on wlast.
  - If wlast disagrees on any beat (high early, or low on the final beat), set an error flag, which gives bresp=10 (SLVERR). Otherwise bresp=00.
  - After the final beat: wready=0 and go to WRESP.
- WRESP:
  - bvalid=1, held until bready.
  - On the handshake: bvalid=0, IDLE.
  - The earliest next AW/AR acceptance is the cycle after return to IDLE.
- Counters are 4-bit. len=15 (16 beats) is supported.
- Address arithmetic is 32-bit with natural overflow wrap; the SRAM index wraps modulo DEPTH.
- There is no read-during-write hazard, since only one transaction is ever active.

Decomposition:
- Shared package axi_pkg:
  - burst codes BURST_FIXED=00, BURST_INCR=01.
  - response codes RESP_OKAY=00, RESP_SLVERR=10.
  - FSM state encoding.
  - default ID_W.
- One sub-module, sram_1rw_be: DEPTH x 32 array with byte-enable synchronous write and combinational read.
- The FSM and address generator live in axi_sram_slave.

Test Plan:
- Single write then read:
  - Stimulus: AW 0x100, len0, size2, wdata 0xDEADBEEF, wstrb 1111; then AR 0x100.
  - Required: bresp 00 with bid=awid; rdata 0xDEADBEEF, rlast=1, rresp 00.
- Cacheline burst:
  - Stimulus: write 8 beats INCR at 0x1FE0 with data 0..7 and correct wlast, then read 8 beats.
  - Required: beats 0..7 in order, rlast only on beat 7, rid=1 when arid=1.
- Byte strobes:
  - Stimulus: preload 0x11223344; single write wstrb 0100, wdata 0x00AA0000, awsize 0.
  - Required: readback 0x11AA3344.
- Read backpressure:
  - Stimulus: 8-beat read with rready toggling 1,0,0,1,...
  - Required: rdata/rlast stable while stalled; no beat lost or repeated.
- Simultaneous AW/AR in IDLE:
  - Required: awready=1 first and the write completes with B; then arready=1 and the read returns the newly written data.
- wlast error and reset:
  - Stimulus: 4-beat write with wlast asserted on beat 2.
  - Required: bresp=10 after 4 beats.
  - Stimulus: assert rst during beat 3 of an 8-beat read.
  - Required: rvalid=0 immediately, FSM in IDLE; a subsequent read succeeds.
